uart_rx_16x: RTL and testbench
==============================

UART_RX_16X -- requirements
Module: uart_rx_16x

Interface
REQ-001 Parameters SHALL be:
- DATA_BITS, 8: payload bits per frame.
- OVERSAMPLE, 16: ticks per bit; legal value 16 only.
- SYNC_STAGES, 2: rx synchronizer depth, minimum 2.

REQ-002 Ports SHALL be:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- tick_16x  in  1  single-clk pulse at 16x baud from the baud generator.
- rx  in  1  asynchronous serial line; idle high.
- rx_ready  in  1  consumer accepts rx_data when high with rx_valid.
- rx_data  out  DATA_BITS  received payload, LSB received first.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- framing_err  out  1  one-clk pulse: stop bit sampled low.
- overrun  out  1  one-clk pulse: byte completed while rx_valid held and not accepted.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 rx SHALL pass through a SYNC_STAGES-flop synchronizer with all stages reset to 1; only the synchronized value (rxs) is used downstream.
REQ-004 State and counter advance SHALL occur only on clk cycles with tick_16x=1; cycles without a tick hold state, except for output handshake logic.
REQ-005 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-006 IDLE: on a tick with rxs=0, go to START with tick counter cnt=0.
REQ-007 Each bit SHALL span cnt 0..15 (4-bit, wraps 15->0); rxs is sampled at cnt 7, 8 and 9; the bit value is the 2-of-3 majority, decided at cnt 9.
REQ-008 START:
- majority 1 at cnt 9: false start; return to IDLE with no output.
- majority 0: continue to cnt 15, then enter DATA with bit index 0.
REQ-009 DATA:
- each decided bit shifts in LSB-first.
- after bit DATA_BITS-1 reaches cnt 15, enter STOP.
REQ-010 STOP is decided at cnt 9 and does not wait for cnt 15:
- majority 1: frame complete; go to IDLE.
- majority 0: pulse framing_err, discard payload, go to WAIT_HIGH.
REQ-011 WAIT_HIGH: on a tick with rxs=1, go to IDLE; a held-low line (break) SHALL NOT generate further frames.
REQ-012 Frame complete with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle:
- load rx_data from the shift register.
- rx_valid=1 from the next clk.
REQ-013 Frame complete with rx_valid=1 and rx_ready=0: pulse overrun, drop the new byte, rx_data unchanged.
REQ-014 rx_valid=1 and rx_ready=1 with no completion: clear rx_valid next clk.
REQ-015 Latency: rx_valid rises exactly one clk after the clk carrying the stop-bit cnt 9 tick.
REQ-016 framing_err and overrun SHALL be high for exactly one clk per event and never simultaneously.
REQ-017 rx_data SHALL change only on a load per REQ-012.

Reset
REQ-018 On rst=1, the next clk SHALL give:
- state IDLE, cnt=0, bit index=0, shift register=0.
- synchronizer stages=1.
- rx_data=0, rx_valid=0, framing_err=0, overrun=0, busy=0.
REQ-019 rst mid-frame SHALL abort the frame with no output; after release, a byte is received only from a new start edge.
REQ-020 tick_16x asserted during rst SHALL be ignored.

Verification
REQ-021 tick every 7 clks, frame 0xA5 with stop=1, rx_ready=1 -> rx_valid one-clk pulse, rx_data=0xA5, no errors.
REQ-022 rx low for 4 ticks then high -> FSM returns to IDLE; no rx_valid, framing_err or overrun; busy falls after cnt 9.
REQ-023 frame 0x3C with stop=0, line then held low 40 ticks, then valid frame 0x81 -> one framing_err pulse, no frame during the low period, then rx_data=0x81.
REQ-024 rx_ready=0; frames 0x11 then 0x22 -> rx_data=0x11, one overrun pulse at the second completion, rx_valid stays 1.
REQ-025 rx_valid=1 holding 0x11; rx_ready=1 in the same clk as completion of 0x22 -> rx_data=0x22, rx_valid stays 1, no overrun.
REQ-026 rst pulsed during DATA bit 4 of 0xFF, then frame 0x5A -> no output from the aborted frame; rx_data=0x5A.

Source files
------------

// File: rtl/uart_rx_16x.sv
// 16x-oversampled UART receiver with 2-of-3 mid-bit voting,
// framing/overrun reporting and a valid/ready output register.
module uart_rx_16x #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_16x,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   samp_a, samp_a_n;
    logic                   samp_b, samp_b_n;
    logic                   maj;
    logic                   done;
    logic                   ferr;

    // Idle-high reset value keeps the FSM from seeing a false start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs  = sync[SYNC_STAGES-1];
    assign maj  = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            samp_a <= samp_a_n;
            samp_b <= samp_b_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        shreg_n  = shreg;
        samp_a_n = samp_a;
        samp_b_n = samp_b;
        done     = 1'b0;
        ferr     = 1'b0;
        if (tick_16x) begin
            cnt_n = cnt + 1'b1;
            if (cnt == C_S0) samp_a_n = rxs;
            if (cnt == C_S1) samp_b_n = rxs;
            unique case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (!rxs) state_n = START;
                end
                START: begin
                    if (cnt == C_S2 && maj) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt == C_LAST) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end
                end
                DATA: begin
                    if (cnt == C_S2) begin
                        shreg_n = {maj, shreg[DATA_BITS-1:1]};
                    end
                    if (cnt == C_LAST) begin
                        if (idx == I_LAST) begin
                            state_n = STOP;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
                // Stop is resolved mid-bit so back-to-back frames keep margin.
                STOP: begin
                    if (cnt == C_S2) begin
                        cnt_n = '0;
                        if (maj) begin
                            done    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            ferr    = 1'b1;
                            state_n = WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    cnt_n = '0;
                    if (rxs) state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= ferr;
            overrun     <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: table of frames plus
// hand-written sequences for false start, break, overrun and reset.
module tb_uart_rx_16x;

    localparam int BIT_CLKS = 112;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_16x;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int n_vrise = 0, n_vcyc = 0, n_ferr = 0, n_ovr = 0;
    int n_bcyc = 0, n_brise = 0, lat_bad = 0, both_bad = 0;
    logic pv = 1'b0, pb = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         rise;
        int         vcyc;
        int         ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vec[5];

    uart_rx_16x dut (
        .clk        (clk),
        .rst        (rst),
        .tick_16x   (tick_16x),
        .rx         (rx),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .framing_err(framing_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One tick every 7 clks, high across exactly one rising edge.
    initial begin
        tick_16x = 1'b0;
        forever begin
            repeat (6) @(negedge clk);
            tick_16x = 1'b1;
            @(negedge clk);
            tick_16x = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (rx_valid) n_vcyc++;
                if (rx_valid && !pv) begin
                    n_vrise++;
                    if (!(pb && !busy && tick_16x)) lat_bad++;
                end
                if (framing_err) n_ferr++;
                if (overrun) n_ovr++;
                if (framing_err && overrun) both_bad++;
                if (busy) n_bcyc++;
                if (busy && !pb) n_brise++;
            end
            pv = rx_valid;
            pb = busy;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: sim time exceeded, expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int low_clks);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        if (low_clks > 0) begin
            rx = 1'b0;
            repeat (low_clks) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    // Wait for busy to rise, then count n ticks after that edge.
    task automatic wait_ticks(input int n, output bit ok);
        int cnt;
        ok  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            for (int i = 0; i < n * 7 + 50 && cnt < n; i++) begin
                @(posedge clk);
                if (tick_16x) cnt++;
            end
            ok = (cnt == n);
        end
    endtask

    initial begin
        int s_rise, s_vcyc, s_ferr, s_ovr, s_bcyc, s_brise;
        bit ok;

        vec[0] = '{8'hA5, 1'b1, 1, 1, 0, 8'hA5};
        vec[1] = '{8'h00, 1'b1, 1, 1, 0, 8'h00};
        vec[2] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
        vec[3] = '{8'h3C, 1'b0, 0, 0, 1, 8'hFF};
        vec[4] = '{8'h81, 1'b1, 1, 1, 0, 8'h81};

        rst      = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        idle(12);
        rst = 1'b0;
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_framing_err", framing_err, 0);
        check("reset_overrun", overrun, 0);
        idle(20);

        for (int i = 0; i < 5; i++) begin
            s_rise = n_vrise;
            s_vcyc = n_vcyc;
            s_ferr = n_ferr;
            s_ovr  = n_ovr;
            send_frame(vec[i].data, vec[i].stop, 0);
            idle(2 * BIT_CLKS);
            check($sformatf("vec%0d_valid_rises", i), n_vrise - s_rise,
                  vec[i].rise);
            check($sformatf("vec%0d_valid_cycles", i), n_vcyc - s_vcyc,
                  vec[i].vcyc);
            check($sformatf("vec%0d_framing_err", i), n_ferr - s_ferr,
                  vec[i].ferr);
            check($sformatf("vec%0d_overrun", i), n_ovr - s_ovr, 0);
            check($sformatf("vec%0d_rx_data", i), rx_data, vec[i].exp_data);
        end

        // False start: 4 ticks low, then high.
        s_rise  = n_vrise;
        s_ferr  = n_ferr;
        s_bcyc  = n_bcyc;
        s_brise = n_brise;
        @(negedge clk);
        rx = 1'b0;
        idle(28);
        rx = 1'b1;
        idle(300);
        check("false_start_busy_rises", n_brise - s_brise, 1);
        check("false_start_busy_cycles", n_bcyc - s_bcyc, 70);
        check("false_start_valid", n_vrise - s_rise, 0);
        check("false_start_ferr", n_ferr - s_ferr, 0);

        // Bad stop, line held low 40 ticks, then a good frame.
        s_rise = n_vrise;
        s_vcyc = n_vcyc;
        s_ferr = n_ferr;
        s_ovr  = n_ovr;
        send_frame(8'h3C, 1'b0, 40 * 7);
        idle(BIT_CLKS);
        check("break_no_frame", n_vrise - s_rise, 0);
        send_frame(8'h81, 1'b1, 0);
        idle(2 * BIT_CLKS);
        check("break_ferr_cycles", n_ferr - s_ferr, 1);
        check("break_valid_rises", n_vrise - s_rise, 1);
        check("break_overrun", n_ovr - s_ovr, 0);
        check("break_rx_data", rx_data, 8'h81);

        // Overrun with consumer stalled.
        rx_ready = 1'b0;
        s_ovr    = n_ovr;
        send_frame(8'h11, 1'b1, 0);
        idle(2 * BIT_CLKS);
        check("stall_first_data", rx_data, 8'h11);
        check("stall_first_valid", rx_valid, 1);
        send_frame(8'h22, 1'b1, 0);
        idle(2 * BIT_CLKS);
        check("overrun_cycles", n_ovr - s_ovr, 1);
        check("overrun_rx_data", rx_data, 8'h11);
        check("overrun_valid_held", rx_valid, 1);

        // Accept in the same clk as the next completion.
        s_ovr = n_ovr;
        fork
            send_frame(8'h22, 1'b1, 0);
            begin
                wait_ticks(153, ok);
                if (ok) begin
                    ok = 1'b0;
                    for (int i = 0; i < 20; i++) begin
                        @(negedge clk);
                        #1;
                        if (tick_16x) begin
                            rx_ready = 1'b1;
                            ok = 1'b1;
                            break;
                        end
                    end
                    @(posedge clk);
                    @(negedge clk);
                    rx_ready = 1'b0;
                end
            end
        join
        check("same_clk_sync_ok", ok, 1);
        idle(BIT_CLKS);
        check("same_clk_rx_data", rx_data, 8'h22);
        check("same_clk_valid", rx_valid, 1);
        check("same_clk_overrun", n_ovr - s_ovr, 0);

        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        check("consume_clears_valid", rx_valid, 0);
        idle(BIT_CLKS);

        // Reset in the middle of data bit 4.
        s_rise = n_vrise;
        s_ferr = n_ferr;
        fork
            send_frame(8'hFF, 1'b1, 0);
            begin
                wait_ticks(88, ok);
                @(negedge clk);
                rst = 1'b1;
                idle(10);
                rst = 1'b0;
            end
        join
        check("midrst_sync_ok", ok, 1);
        idle(2 * BIT_CLKS);
        check("midrst_no_valid", n_vrise - s_rise, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rx_data", rx_data, 0);
        send_frame(8'h5A, 1'b1, 0);
        idle(2 * BIT_CLKS);
        check("after_rst_rises", n_vrise - s_rise, 1);
        check("after_rst_rx_data", rx_data, 8'h5A);
        check("after_rst_ferr", n_ferr - s_ferr, 0);

        check("valid_latency_violations", lat_bad, 0);
        check("ferr_overrun_overlap", both_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
